// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) running entirely in the
// sys_clk domain. SPI pins are oversampled through 2-flop synchronizers. A
// third spi_clk flop produces one-cycle rise/fall strobes, and a third spi_csn
// flop produces the frame-start edge.
//
// Ports
//   sys_clk       system clock
//   sys_rst_n     asynchronous active-low reset
//   spi_csn       chip select from master, active low (asynchronous)
//   spi_clk       SPI clock from master (asynchronous)
//   spi_mosi      master-to-slave data (asynchronous)
//   spi_miso      slave-to-master data, registered, 0 while not ACTIVE
//   tx_data       next word to return to the master
//   tx_valid      tx_data offered
//   tx_ready      single-entry holding register is empty
//   rx_data       last complete received word, held until the next one
//   rx_valid      one-cycle pulse when rx_data is updated
//   frame_active  FSM state: high while ACTIVE (debug view of the FSM)
//   byte_cnt      words completed in the current frame, saturates at 255
//   tx_underrun   one-cycle pulse when DUMMY is loaded at a word boundary
//   frame_error   one-cycle pulse when CSN rises mid-word
//
// Handshake: a word moves from tx_data into the holding register on every
// sys_clk edge where tx_valid && tx_ready. tx_valid may be held high while
// tx_ready is low, and tx_data must stay stable until that transfer happens.
// tx_ready is purely ~full, so it never drops in the cycle of a consume.
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] DUMMY  = 8'hFF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_csn,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active,
  output logic [7:0]        byte_cnt,
  output logic              tx_underrun,
  output logic              frame_error
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state;

  // Synchronizer stages.
  logic csn_s1, csn_s2, csn_s3;
  logic clk_s1, clk_s2, clk_s3;
  logic mosi_s1, mosi_s2;

  // Datapath.
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;

  logic              rise;
  logic              fall;
  logic              csn_fall;
  logic              hold_wr;
  logic [DATA_W-1:0] rx_word;

  // The CSN chain resets low. A CSN that is already low when reset is
  // released therefore shows no falling edge, and no frame starts until CSN
  // has been seen high and then low again.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csn_s1  <= 1'b0;
      csn_s2  <= 1'b0;
      csn_s3  <= 1'b0;
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      csn_s1  <= spi_csn;
      csn_s2  <= csn_s1;
      csn_s3  <= csn_s2;
      clk_s1  <= spi_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign rise     = clk_s2 & ~clk_s3;
  assign fall     = ~clk_s2 & clk_s3;
  assign csn_fall = csn_s3 & ~csn_s2;

  assign tx_ready     = ~hold_full;
  assign hold_wr      = tx_valid & tx_ready;
  assign frame_active = (state == ACTIVE);
  assign rx_word      = {rx_sr, mosi_s2};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_cnt    <= 8'd0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
      spi_miso    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
      spi_miso    <= (state == ACTIVE) ? tx_sr[DATA_W-1] : 1'b0;

      // A write only happens while empty and a consume only while full,
      // so the two never compete for hold_full.
      if (hold_wr) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (csn_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            byte_cnt <= 8'd0;
            // The first word of a frame never reports an underrun.
            if (hold_full) begin
              tx_sr     <= hold_data;
              hold_full <= 1'b0;
            end else begin
              tx_sr <= DUMMY;
            end
          end
        end

        ACTIVE: begin
          if (csn_s2) begin
            // CSN high wins over any clock edge in the same cycle. A partial
            // word is dropped, and the holding register keeps its contents.
            state <= IDLE;
            if (bit_cnt != '0) frame_error <= 1'b1;
          end else if (rise) begin
            rx_sr <= rx_word[DATA_W-2:0];
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (fall) begin
            if (bit_cnt != '0) begin
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end else if (byte_cnt != 8'd0) begin
              // This is the word boundary after at least one completed word.
              // byte_cnt saturates rather than wrapping, so a non-zero value
              // reliably means a word has been completed. A fall seen before
              // the first rise of the frame is ignored.
              if (hold_full) begin
                tx_sr     <= hold_data;
                hold_full <= 1'b0;
              end else begin
                tx_sr       <= DUMMY;
                tx_underrun <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam logic [7:0] DUMMY = 8'hFF;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       spi_csn   = 1'b1;
  logic       spi_clk   = 1'b0;
  logic       spi_mosi  = 1'b0;
  logic       spi_miso;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_active;
  logic [7:0] byte_cnt;
  logic       tx_underrun;
  logic       frame_error;

  spi_slave dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .spi_csn      (spi_csn),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_active (frame_active),
    .byte_cnt     (byte_cnt),
    .tx_underrun  (tx_underrun),
    .frame_error  (frame_error)
  );

  // ---------------------------------------------------------------- clock/reset
  always #10 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------- scoreboard
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hold_q[$];
  int         un_cnt = 0;
  int         fe_cnt = 0;
  int         fa_cnt = 0;
  int         miso_hi_cnt = 0;
  int         master_word = -1;
  logic [7:0] frame_mosi [0:3];
  logic [7:0] got_miso [0:3];
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected progress", name);
  endtask

  // Monitor: received words are popped against the expected queue.
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_unexpected: got rx_valid with 0x%0h, expected no word", rx_data);
      end else begin
        check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
    if (tx_underrun)  un_cnt++;
    if (frame_error)  fe_cnt++;
    if (frame_active) fa_cnt++;
    if (spi_miso)     miso_hi_cnt++;
  end

  // ---------------------------------------------------------------- drivers
  // All drivers are entered and leave on a sys_clk negedge.
  task automatic tx_write(input logic [7:0] d);
    int t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (!tx_ready) begin
      tx_valid = 1'b0;
      fail_timeout("tx_write");
    end else begin
      @(negedge sys_clk);
      tx_valid = 1'b0;
      check("tx_ready_when_full", 32'(tx_ready), 32'd0);
    end
  endtask

  // Mode-0 master: MOSI changes with the falling clock, MISO is captured as the
  // clock rises. On the last bit the clock falls together with CSN rising.
  task automatic run_frame(input int nbits, input int half, input int setup, input int gap);
    spi_csn  = 1'b0;
    spi_mosi = frame_mosi[0][7];
    repeat (setup) @(negedge sys_clk);
    for (int k = 0; k < nbits; k++) begin
      if (k % 8 == 0) begin
        check("tx_ready_at_word_start", 32'(tx_ready), 32'd1);
        check("byte_cnt_at_word_start", 32'(byte_cnt), 32'(k / 8));
        master_word = k / 8;
      end
      got_miso[k / 8][7 - (k % 8)] = spi_miso;
      spi_clk = 1'b1;
      repeat (half) @(negedge sys_clk);
      spi_clk = 1'b0;
      if (k == nbits - 1) begin
        spi_csn = 1'b1;
        repeat (gap) @(negedge sys_clk);
      end else begin
        spi_mosi = frame_mosi[(k + 1) / 8][7 - ((k + 1) % 8)];
        repeat (half) @(negedge sys_clk);
      end
    end
    master_word = -1;
  endtask

  task automatic writer(input int n, input logic [3:0] wr_en, input logic [31:0] wr);
    for (int k = 0; k < n; k++) begin
      if (wr_en[k]) begin
        int t = 0;
        while (master_word != k && t < 5000) begin
          @(negedge sys_clk);
          t++;
        end
        if (master_word != k) fail_timeout("writer_wait");
        else tx_write(wr[8*k +: 8]);
      end
    end
  endtask

  task automatic run_and_check(input string name, input int n, input logic [31:0] mosi,
                               input logic pre_en, input logic [7:0] pre,
                               input logic [3:0] wr_en, input logic [31:0] wr,
                               input logic [31:0] exp_miso, input int exp_un,
                               input int half, input int setup, input int gap);
    un_cnt = 0;
    fe_cnt = 0;
    if (pre_en) tx_write(pre);
    for (int b = 0; b < 4; b++) begin
      frame_mosi[b] = mosi[8*b +: 8];
      got_miso[b]   = 8'h00;
    end
    for (int b = 0; b < n; b++) exp_q.push_back(mosi[8*b +: 8]);
    fork
      run_frame(8 * n, half, setup, gap);
      writer(n, wr_en, wr);
    join
    check($sformatf("%s/rx_words_missing", name), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int b = 0; b < n; b++)
      check($sformatf("%s/miso%0d", name, b), 32'(got_miso[b]), 32'(exp_miso[8*b +: 8]));
    check($sformatf("%s/underruns", name), 32'(un_cnt), 32'(exp_un));
    check($sformatf("%s/frame_error", name), 32'(fe_cnt), 32'd0);
    check($sformatf("%s/byte_cnt", name), 32'(byte_cnt), 32'(n));
    check($sformatf("%s/frame_active_end", name), 32'(frame_active), 32'd0);
    last_rx = mosi[8*(n-1) +: 8];
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] mosi;      // byte b in [8b+7:8b], byte 0 sent first
    logic        pre_en;
    logic [7:0]  pre;
    logic [3:0]  wr_en;     // bit k: write wr byte k while word k shifts
    logic [31:0] wr;
    logic [31:0] exp_miso;
    logic [2:0]  exp_un;
  } vec_t;

  vec_t vecs [6];

  localparam logic [21:0] RESET_OUTS = {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

  initial begin
    int          n;
    logic [31:0] mosi;
    logic        pre_en;
    logic [7:0]  pre;
    logic [3:0]  wr_en;
    logic [31:0] wr;
    logic [31:0] em;
    int          un;
    int          half;
    int          setup;

    vecs[0] = '{3'd1, 32'h000000A5, 1'b1, 8'h3C, 4'b0000, 32'h0,        32'h0000003C, 3'd0};
    vecs[1] = '{3'd3, 32'h00563412, 1'b1, 8'h81, 4'b0000, 32'h0,        32'h00FFFF81, 3'd2};
    vecs[2] = '{3'd2, 32'h00007EC3, 1'b1, 8'h11, 4'b0001, 32'h00000022, 32'h00002211, 3'd0};
    vecs[3] = '{3'd1, 32'h00000099, 1'b0, 8'h00, 4'b0001, 32'h00000077, 32'h000000FF, 3'd0};
    vecs[4] = '{3'd2, 32'h00000201, 1'b0, 8'h00, 4'b0000, 32'h0,        32'h0000FF77, 3'd1};
    vecs[5] = '{3'd4, 32'hEFBEADDE, 1'b1, 8'hC5, 4'b0101, 32'h00B200A0, 32'hB2FFA0C5, 3'd1};

    // Reset state.
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", 32'({spi_miso, tx_ready, rx_data, rx_valid, frame_active,
                                byte_cnt, tx_underrun, frame_error}), 32'(RESET_OUTS));
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Table-driven frames.
    for (int i = 0; i < 6; i++)
      run_and_check($sformatf("vec%0d", i), int'(vecs[i].n), vecs[i].mosi, vecs[i].pre_en,
                    vecs[i].pre, vecs[i].wr_en, vecs[i].wr, vecs[i].exp_miso,
                    int'(vecs[i].exp_un), 5, 8, 8);

    // CSN rises after 5 bits of 0xF0.
    un_cnt = 0;
    fe_cnt = 0;
    frame_mosi[0] = 8'hF0;
    run_frame(5, 5, 8, 8);
    check("abort/frame_error", 32'(fe_cnt), 32'd1);
    check("abort/rx_data_held", 32'(rx_data), 32'(last_rx));
    check("abort/frame_active", 32'(frame_active), 32'd0);
    run_and_check("after_abort", 1, 32'h5A, 1'b0, 8'h00, 4'b0, 32'h0, 32'hFF, 0, 5, 8, 8);

    // Reset asserted mid-byte with a word in the holding register.
    un_cnt = 0;
    fe_cnt = 0;
    spi_csn  = 1'b0;
    spi_mosi = 1'b1;
    repeat (8) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      spi_clk = 1'b1;
      repeat (4) @(negedge sys_clk);
      spi_clk = 1'b0;
      repeat (4) @(negedge sys_clk);
    end
    check("rst_seq/frame_active_before", 32'(frame_active), 32'd1);
    tx_write(8'hAB);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("rst_seq/outputs_in_reset", 32'({spi_miso, tx_ready, rx_data, rx_valid, frame_active,
                                           byte_cnt, tx_underrun, frame_error}), 32'(RESET_OUTS));
    @(negedge sys_clk);
    repeat (2) @(negedge sys_clk);
    sys_rst_n   = 1'b1;
    fa_cnt      = 0;
    miso_hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      spi_clk  = ~spi_clk;
      repeat (4) @(negedge sys_clk);
    end
    spi_clk = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("rst_seq/no_frame_with_csn_low", 32'(fa_cnt), 32'd0);
    check("rst_seq/miso_quiet", 32'(miso_hi_cnt), 32'd0);
    check("rst_seq/no_frame_error", 32'(fe_cnt), 32'd0);
    check("rst_seq/no_underrun", 32'(un_cnt), 32'd0);
    spi_csn = 1'b1;
    repeat (6) @(negedge sys_clk);
    run_and_check("post_reset", 1, 32'hC7, 1'b0, 8'h00, 4'b0, 32'h0, 32'hFF, 0, 5, 8, 8);

    // Minimum timing, back-to-back frames.
    for (int f = 0; f < 4; f++)
      run_and_check($sformatf("min_timing%0d", f), 2, (f % 2 == 0) ? 32'h0000FF00 : 32'h000000FF,
                    1'b0, 8'h00, 4'b0, 32'h0, 32'h0000FFFF, 1, 4, 6, 4);

    // Randomized frames against a queue model of the holding register.
    hold_q.delete();
    for (int r = 0; r < 24; r++) begin
      n      = int'($urandom_range(1, 4));
      mosi   = $urandom();
      pre_en = 1'($urandom_range(0, 1));
      pre    = 8'($urandom_range(0, 255));
      wr_en  = 4'($urandom_range(0, 15));
      wr     = $urandom();
      half   = int'($urandom_range(4, 7));
      setup  = int'($urandom_range(6, 10));
      if (hold_q.size() != 0) pre_en = 1'b0;
      if (pre_en) hold_q.push_back(pre);
      em = 32'h0;
      un = 0;
      em[7:0] = (hold_q.size() != 0) ? hold_q.pop_front() : DUMMY;
      for (int k = 0; k < n; k++) begin
        if (wr_en[k]) hold_q.push_back(wr[8*k +: 8]);
        if (k < n - 1) begin
          if (hold_q.size() != 0) begin
            em[8*(k+1) +: 8] = hold_q.pop_front();
          end else begin
            em[8*(k+1) +: 8] = DUMMY;
            un++;
          end
        end
      end
      run_and_check($sformatf("rand%0d", r), n, mosi, pre_en, pre, wr_en, wr, em, un,
                    half, setup, 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) clocked by `sys_clk`. It is the target-side counterpart to `spi_top`. It deserialises `spi_mosi` into bytes and serialises a queued transmit byte onto `spi_miso`. It serves two purposes: it stands in for the flash/DDS device in system simulation, and it provides a synthesizable loopback responder for board bring-up of the master. All SPI inputs are treated as asynchronous and are oversampled in `sys_clk`.

## Interface
Reset is asynchronous and active-low.

Parameters:
- `DATA_W`, default 8: bits per SPI word.
- `DUMMY`, default 8'hFF: word shifted out when no transmit byte is queued.

Ports (name, direction, width, meaning):
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `spi_csn`  in  1  chip select from master, active low.
- `spi_clk`  in  1  SPI clock from master.
- `spi_mosi`  in  1  master-to-slave data.
- `spi_miso`  out  1  slave-to-master data; 0 while deselected.
- `tx_data`  in  DATA_W  next word to return to the master.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  high when the holding register is empty. A transfer happens when `tx_valid` && `tx_ready`.
- `rx_data`  out  DATA_W  last complete received word; held until the next word completes.
- `rx_valid`  out  1  one-cycle pulse when a word completes.
- `frame_active`  out  1  high while in the ACTIVE state.
- `byte_cnt`  out  8  words completed in the current frame; saturates at 255.
- `tx_underrun`  out  1  one-cycle pulse when `DUMMY` is loaded at a word boundary.
- `frame_error`  out  1  one-cycle pulse when CSN deasserts mid-word.

## Operation
Input conditioning:
- `spi_csn`, `spi_clk` and `spi_mosi` each pass through a 2-flop synchronizer.
- `spi_clk` gets a third flop for edge detection, producing one-cycle pulses `rise` and `fall`.

States: IDLE and ACTIVE.
- IDLE → ACTIVE on a synchronized CSN falling edge.
  - `bit_cnt` is cleared to 0 and `byte_cnt` to 0.
  - The TX shift register loads the holding register if it is full, and the holding register is cleared.
  - Otherwise the TX shift register loads `DUMMY`, with no underrun pulse for this first word.
- ACTIVE → IDLE on a synchronized CSN high. This takes priority over `rise` and `fall` in the same cycle.
  - If `bit_cnt` != 0, `frame_error` pulses and the partial RX word is discarded, with no `rx_valid`.
  - The holding register keeps its contents.

ACTIVE behaviour:
- **`rise`:**
  - The RX shift register takes `{rx_sr[DATA_W-2:0], mosi_s}`.
  - `bit_cnt` increments.
  - At `bit_cnt` == DATA_W-1, the assembled word goes to `rx_data`; `rx_valid` pulses the next cycle, `byte_cnt` increments, and `bit_cnt` wraps to 0.
- **`fall` with `bit_cnt` != 0:** the TX shift register shifts left by 1.
- **`fall` with `bit_cnt` == 0 and at least one word done in this frame:** the TX shift register reloads, either from the holding register (clearing it) or with `DUMMY` plus a `tx_underrun` pulse.
- **`fall` before the first rise of the frame:** ignored.

Output and buffering rules:
- `spi_miso` is registered as TX shift register[MSB] when ACTIVE, and 0 otherwise.
- Holding register:
  - It is a single entry.
  - `tx_ready` = ~full, combinational.
  - A write and an internal consume never coincide, because `tx_ready` is low whenever full.

Reset values:
- `spi_miso` = 0, `tx_ready` = 1, `rx_data` = 0.
- `rx_valid`, `frame_active`, `tx_underrun` and `frame_error` = 0.
- `byte_cnt` = 0.
- State = IDLE and the holding register is empty.
- Reset asserted mid-frame aborts immediately, with no pulses. After release, the block waits for a fresh CSN falling edge, so a CSN already low at release is not a frame start.

## Timing
- Input latency: 3 `sys_clk` cycles from an SPI pin edge to `rise`/`fall`/CSN detection.
- `rx_valid`: 1 cycle after the `rise` of the last bit, i.e. 4–5 `sys_clk` after the pin edge.
- `spi_miso` update: 1 cycle after `fall`. The first bit is valid 4 cycles after CSN falls.
- Master setup requirements:
  - CSN low to first `spi_clk` rise ≥ 6 `sys_clk`.
  - `spi_clk` high and low phases ≥ 4 `sys_clk` each, so `spi_clk` ≤ 6.25 MHz at 50 MHz.
- After CSN rise, the next CSN fall needs ≥ 4 `sys_clk`.
- `tx_data` must be written before the `fall` that follows the last `rise` of the current word, to avoid an underrun.

## Test plan
- Reset, then preload `tx_data`=0x3C, then send a 1-byte frame with MOSI 0xA5 → `rx_data`=0xA5 and one `rx_valid`; the master captures 0x3C; `byte_cnt`=1; no underrun or frame error.
- A 3-byte frame with MOSI 0x12,0x34,0x56, where only 0x81 is preloaded before CSN and nothing is queued afterwards → `rx_valid` ×3 with the correct bytes; MISO returns 0x81,0xFF,0xFF; `tx_underrun` pulses 2 times; `byte_cnt`=3.
- CSN deasserted after 5 bits of 0xF0 → `frame_error` pulses once, no `rx_valid`, `rx_data` unchanged; the next full frame carrying 0x5A is received correctly.
- Refill during a frame: write 0x11 at frame start, then 0x22 while byte 0 is shifting → MISO returns 0x11,0x22 with no underrun; `tx_ready` is low while full and returns high after each load.
- Assert `sys_rst_n` mid-byte → all outputs return to reset values within 1 cycle, with no pulses; with CSN still low after release, no frame starts until CSN toggles high then low.
- Boundary check with minimum timing (CSN setup 6 cycles, 4-cycle `spi_clk` phases), 4 back-to-back frames of 0x00 and 0xFF → all bytes are received, and `byte_cnt` resets to 0 at each frame start.
